// File: rtl/led_stretch_pkg.sv
// Shared types and elaboration helpers for the LED pulse stretcher.
package led_stretch_pkg;

    typedef enum logic [1:0] {IDLE, ON, OFF} state_t;

    function automatic int ns_to_cyc(input int ns, input int clk_ns);
        return ns / clk_ns;
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/led_stretch_if.sv
// Event-in / LED-status bundle between an event source and led_stretch.
interface led_stretch_if #(
    parameter int PW = 3
) ();
    logic          evt_in;
    logic          led_out;
    logic          busy;
    logic [PW-1:0] pend_cnt;
    logic          overflow;

    modport master (output evt_in, input led_out, busy, pend_cnt, overflow);
    modport slave  (input evt_in, output led_out, busy, pend_cnt, overflow);
endinterface

// File: rtl/led_stretch_tick_timer.sv
// Loadable down-counter that parks at zero; zero flag reflects the current count.
module tick_timer #(
    parameter int W = 4
) (
    input  logic         sysclk,
    input  logic         sysrst,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         zero
);
    logic [W-1:0] cnt;

    always_ff @(posedge sysclk) begin
        if (sysrst)
            cnt <= '0;
        else if (load)
            cnt <= value;
        else if (cnt != '0)
            cnt <= cnt - W'(1);
    end

    assign zero = (cnt == '0);
endmodule

// File: rtl/led_stretch.sv
// Stretches single-cycle events into visible LED blinks with a queued backlog.
// Build option: LED_STRETCH_ACTIVE_LOW_EN inverts led_out for active-low LEDs.
module led_stretch
    import led_stretch_pkg::*;
#(
    parameter int CLK_CYC  = 10,
    parameter int ON_TIME  = 50_000_000,
    parameter int OFF_TIME = 50_000_000,
    parameter int PEND_MAX = 7
) (
    input logic         sysclk,
    input logic         sysrst,
    led_stretch_if.slave bus
);
    localparam int ON_CNT  = ns_to_cyc(ON_TIME, CLK_CYC);
    localparam int OFF_CNT = ns_to_cyc(OFF_TIME, CLK_CYC);
    localparam int TW      = $clog2(max2(ON_CNT, OFF_CNT) + 1);
    localparam int PW      = $clog2(PEND_MAX + 1);

`ifdef LED_STRETCH_ACTIVE_LOW_EN
    localparam logic LED_POL = 1'b1;
`else
    localparam logic LED_POL = 1'b0;
`endif

    generate
        if (ON_CNT < 1 || OFF_CNT < 1) begin : g_bad_timing
            $error("led_stretch: ON_CNT and OFF_CNT must both be >= 1");
        end
    endgenerate

    state_t          state, next_state;
    logic            tmr_load, tmr_zero;
    logic [TW-1:0]   tmr_val;
    logic            pend_inc, pend_dec;
    logic [PW-1:0]   pend;

    tick_timer #(.W(TW)) u_timer (
        .sysclk (sysclk),
        .sysrst (sysrst),
        .load   (tmr_load),
        .value  (tmr_val),
        .zero   (tmr_zero)
    );

    always_ff @(posedge sysclk) begin
        if (sysrst)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        tmr_load   = 1'b0;
        tmr_val    = '0;
        pend_dec   = 1'b0;
        case (state)
            IDLE: if (bus.evt_in) begin
                next_state = ON;
                tmr_load   = 1'b1;
                tmr_val    = TW'(ON_CNT - 1);
            end
            ON: if (tmr_zero) begin
                next_state = OFF;
                tmr_load   = 1'b1;
                tmr_val    = TW'(OFF_CNT - 1);
            end
            OFF: if (tmr_zero) begin
                if (pend != '0) begin
                    next_state = ON;
                    tmr_load   = 1'b1;
                    tmr_val    = TW'(ON_CNT - 1);
                    pend_dec   = 1'b1;
                end else begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // IDLE events launch a blink directly and never enter the backlog.
    assign pend_inc = bus.evt_in && (state != IDLE);

    always_ff @(posedge sysclk) begin
        if (sysrst) begin
            pend         <= '0;
            bus.overflow <= 1'b0;
            bus.led_out  <= LED_POL;
            bus.busy     <= 1'b0;
        end else begin
            bus.led_out <= (next_state == ON) ^ LED_POL;
            bus.busy    <= (next_state != IDLE);
            if (pend_inc && !pend_dec) begin
                if (pend == PW'(PEND_MAX))
                    bus.overflow <= 1'b1;
                else
                    pend <= pend + PW'(1);
            end else if (pend_dec && !pend_inc) begin
                pend <= pend - PW'(1);
            end
        end
    end

    assign bus.pend_cnt = pend;
endmodule

// File: tb/tb_led_stretch.sv
// Self-checking bench for led_stretch: directed scenarios plus random events vs a blink-schedule model.
module tb_led_stretch;
    localparam int CLK_CYC  = 10;
    localparam int ON_TIME  = 100;
    localparam int OFF_TIME = 50;
    localparam int PEND_MAX = 3;
    localparam int ON_CNT   = ON_TIME / CLK_CYC;
    localparam int OFF_CNT  = OFF_TIME / CLK_CYC;
    localparam int PW       = $clog2(PEND_MAX + 1);

`ifdef LED_STRETCH_ACTIVE_LOW_EN
    localparam bit LED_POL = 1'b1;
`else
    localparam bit LED_POL = 1'b0;
`endif

    logic sysclk, sysrst;
    led_stretch_if #(.PW(PW)) bus ();

    led_stretch #(
        .CLK_CYC(CLK_CYC), .ON_TIME(ON_TIME), .OFF_TIME(OFF_TIME), .PEND_MAX(PEND_MAX)
    ) dut (
        .sysclk (sysclk),
        .sysrst (sysrst),
        .bus    (bus.slave)
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    int checks = 0;
    int errors = 0;

    // Model: a blink is anchored at the edge that launched it; everything else is derived from it.
    int t = 0;
    bit m_act = 0;
    int m_anchor = 0;
    int m_pend = 0;
    bit m_ovf = 0;
    bit m_led = 0;
    bit m_busy = 0;

    logic [PW+2:0] obs;
    logic          led_lvl;
    assign obs     = {bus.led_out, bus.busy, bus.pend_cnt, bus.overflow};
    assign led_lvl = bus.led_out ^ LED_POL;

    function automatic logic [PW+2:0] model_out();
        return {m_led ^ LED_POL, m_busy, PW'(m_pend), m_ovf};
    endfunction

    task automatic step(input bit e, input bit r);
        bit dec_edge, relaunch;
        bus.evt_in = e;
        sysrst     = r;
        @(posedge sysclk);
        relaunch = 1'b0;
        if (r) begin
            m_act = 0; m_pend = 0; m_ovf = 0;
        end else if (!m_act) begin
            if (e) begin m_act = 1; m_anchor = t; end
        end else begin
            dec_edge = (t - m_anchor == ON_CNT + OFF_CNT);
            if (dec_edge) begin
                if (m_pend > 0) begin m_anchor = t; relaunch = 1'b1; end
                else m_act = 0;
            end
            if (e && !relaunch) begin
                if (m_pend == PEND_MAX) m_ovf = 1;
                else m_pend++;
            end
            if (relaunch && !e) m_pend--;
        end
        m_busy = m_act;
        m_led  = m_act && (t - m_anchor < ON_CNT);
        t++;
        #1;
        bus.evt_in = 1'b0;
        sysrst     = 1'b0;
    endtask

    task automatic test_reset();
        step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        checks++;
        if (bus.led_out !== LED_POL) begin errors++; $display("FAIL reset_led got %b want %b", bus.led_out, LED_POL); end
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        checks++;
        if (bus.pend_cnt !== '0) begin errors++; $display("FAIL reset_pend got %0d want 0", bus.pend_cnt); end
        checks++;
        if (bus.overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", bus.overflow); end
    endtask

    task automatic test_single();
        int first_on = -1, on_cnt = 0, busy_fall = -1, pmax = 0;
        step(1'b0, 1'b1);
        for (int k = 0; k < 22; k++) begin
            step(k == 0, 1'b0);
            checks++;
            if (obs !== model_out()) begin errors++; $display("FAIL single c=%0d got %b want %b", k + 1, obs, model_out()); end
            if (led_lvl) begin on_cnt++; if (first_on < 0) first_on = k + 1; end
            if (!bus.busy && busy_fall < 0 && k > 0) busy_fall = k + 1;
            if (int'(bus.pend_cnt) > pmax) pmax = int'(bus.pend_cnt);
        end
        checks++;
        if (first_on !== 1 || on_cnt !== 10) begin errors++; $display("FAIL single_on got first=%0d n=%0d want 1 10", first_on, on_cnt); end
        checks++;
        if (busy_fall !== 16) begin errors++; $display("FAIL single_busy_fall got %0d want 16", busy_fall); end
        checks++;
        if (pmax !== 0) begin errors++; $display("FAIL single_pend got %0d want 0", pmax); end
    endtask

    task automatic test_burst();
        int rises[$];
        int idle_at = -1;
        bit prev = 0;
        step(1'b0, 1'b1);
        for (int k = 0; k < 50; k++) begin
            step(k <= 2, 1'b0);
            checks++;
            if (obs !== model_out()) begin errors++; $display("FAIL burst c=%0d got %b want %b", k + 1, obs, model_out()); end
            if (k == 2) begin
                checks++;
                if (bus.pend_cnt !== PW'(2)) begin errors++; $display("FAIL burst_pend3 got %0d want 2", bus.pend_cnt); end
            end
            if (led_lvl && !prev) rises.push_back(k + 1);
            prev = led_lvl;
            if (!bus.busy && idle_at < 0 && k > 0) idle_at = k + 1;
        end
        checks++;
        if (rises.size() != 3 || rises[0] != 1 || rises[1] != 16 || rises[2] != 31) begin
            errors++; $display("FAIL burst_rises got %0d rises want 1,16,31", rises.size());
        end
        checks++;
        if (idle_at !== 46) begin errors++; $display("FAIL burst_idle got %0d want 46", idle_at); end
    endtask

    task automatic test_overflow();
        int blinks = 0;
        bit prev = 0;
        step(1'b0, 1'b1);
        for (int k = 0; k < 80; k++) begin
            step(k <= 5, 1'b0);
            checks++;
            if (obs !== model_out()) begin errors++; $display("FAIL ovf c=%0d got %b want %b", k + 1, obs, model_out()); end
            if (led_lvl && !prev) blinks++;
            prev = led_lvl;
        end
        checks++;
        if (blinks !== 4) begin errors++; $display("FAIL ovf_blinks got %0d want 4", blinks); end
        checks++;
        if (bus.overflow !== 1'b1 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL ovf_sticky got ovf=%b busy=%b want 1 0", bus.overflow, bus.busy);
        end
    endtask

    task automatic test_simul();
        step(1'b0, 1'b1);
        for (int k = 0; k < 50; k++) begin
            step(k == 0 || k == 3 || k == 15, 1'b0);
            checks++;
            if (obs !== model_out()) begin errors++; $display("FAIL simul1 c=%0d got %b want %b", k + 1, obs, model_out()); end
            if (k == 15) begin
                checks++;
                if (bus.pend_cnt !== PW'(1) || led_lvl !== 1'b1) begin
                    errors++; $display("FAIL simul1_c16 got pend=%0d led=%b want 1 1", bus.pend_cnt, led_lvl);
                end
            end
        end
        step(1'b0, 1'b1);
        for (int k = 0; k < 80; k++) begin
            step(k <= 3 || k == 15, 1'b0);
            checks++;
            if (obs !== model_out()) begin errors++; $display("FAIL simul3 c=%0d got %b want %b", k + 1, obs, model_out()); end
            if (k == 15) begin
                checks++;
                if (bus.pend_cnt !== PW'(3) || bus.overflow !== 1'b0 || led_lvl !== 1'b1) begin
                    errors++; $display("FAIL simul3_c16 got pend=%0d ovf=%b led=%b want 3 0 1", bus.pend_cnt, bus.overflow, led_lvl);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int on_cnt = 0;
        step(1'b0, 1'b1);
        for (int k = 0; k < 5; k++) step(k <= 2, 1'b0);
        step(1'b0, 1'b1);
        checks++;
        if (obs !== {LED_POL, 1'b0, PW'(0), 1'b0}) begin errors++; $display("FAIL reset_mid got %b want %b", obs, {LED_POL, 1'b0, PW'(0), 1'b0}); end
        step(1'b0, 1'b0);
        for (int k = 0; k < 20; k++) begin
            step(k == 0, 1'b0);
            checks++;
            if (obs !== model_out()) begin errors++; $display("FAIL reset_mid_after c=%0d got %b want %b", k + 1, obs, model_out()); end
            if (led_lvl) on_cnt++;
        end
        checks++;
        if (on_cnt !== 10) begin errors++; $display("FAIL reset_mid_blink got %0d want 10", on_cnt); end
    endtask

    task automatic test_random();
        step(1'b0, 1'b1);
        for (int k = 0; k < 4000; k++) begin
            step($urandom_range(0, 5) == 0, $urandom_range(0, 399) == 0);
            checks++;
            if (obs !== model_out()) begin errors++; $display("FAIL random k=%0d got %b want %b", k, obs, model_out()); end
        end
    endtask

    initial begin
        sysrst     = 1'b1;
        bus.evt_in = 1'b0;
        test_reset();
        test_single();
        test_burst();
        test_overflow();
        test_simul();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/led_stretch.md
# led_stretch

Output-side companion to the key debouncer: turns single-cycle internal event pulses into blinks a human can see on a board LED. Typical event sources are SDRAM init done, a refresh error or a test pass/fail. Each accepted event produces one LED pulse with a guaranteed minimum on-time and off-gap. Events arriving while a blink is in progress are queued in a saturating counter, so bursts are shown as distinct blinks rather than merged.

## Interface
- `CLK_CYC`, 10, `sysclk` period in ns
- `ON_TIME`, 50_000_000, LED on-time in ns (50 ms)
- `OFF_TIME`, 50_000_000, minimum dark gap between blinks in ns
- `PEND_MAX`, 7, maximum number of queued events
- `sysclk` input 1: single system clock, all logic on the rising edge
- `sysrst` input 1: reset, **synchronous, active-high**
- `evt_in` input 1: event pulse, synchronous to `sysclk`; every high cycle counts as one event
- `led_out` output 1: LED drive, registered
- `busy` output 1: high whenever the state is not IDLE
- `pend_cnt` output PW: queued events not yet shown, where PW = $clog2(PEND_MAX+1)
- `overflow` output 1: sticky flag, set when an event was dropped

## Operation
- Derived constants:
  - ON_CNT = ON_TIME/CLK_CYC
  - OFF_CNT = OFF_TIME/CLK_CYC
  - Both must be ≥1; elaboration fails otherwise.
  - Timer width = $clog2(max(ON_CNT,OFF_CNT)+1).
- FSM states: IDLE, ON, OFF.
- IDLE:
  - `evt_in`=1 → ON; the timer loads ON_CNT-1.
  - `pend_cnt` is not touched on this transition.
- ON:
  - `led_out`=1 while in this state.
  - Timer decrements each cycle; at 0 → OFF and the timer loads OFF_CNT-1.
- OFF:
  - `led_out`=0 while in this state.
  - At timer 0 with `pend_cnt`>0 → ON, `pend_cnt` decrements and the timer loads ON_CNT-1.
  - At timer 0 with `pend_cnt`=0 → IDLE.
- `evt_in` while in ON or OFF:
  - `pend_cnt` increments, saturating at PEND_MAX.
  - An event arriving at saturation is dropped and sets `overflow`.
- Simultaneous increment and decrement (event on the last OFF cycle while `pend_cnt`>0): the net count is unchanged.
- The same simultaneity at `pend_cnt`=PEND_MAX: the count stays PEND_MAX and `overflow` is not set.
- `overflow` is cleared only by `sysrst`.
- `sysrst` in any state, including mid-blink, takes effect the next cycle:
  - state IDLE, timer 0
  - `led_out`=0, `busy`=0
  - `pend_cnt`=0, `overflow`=0

## Timing
- Reset values: `led_out`=0 (1 when inverted, see Configuration), `busy`=0, `pend_cnt`=0, `overflow`=0.
- Event sampled at cycle n while IDLE:
  - `led_out` is high in cycles n+1 .. n+ON_CNT.
  - `led_out` is low for OFF_CNT cycles after that.
  - The next queued blink starts at n+ON_CNT+OFF_CNT+1.
- `busy` rises one cycle after an accepted IDLE event. It falls in the cycle the FSM re-enters IDLE.
- `pend_cnt` and `overflow` update one cycle after the event edge.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- Macro `LED_STRETCH_ACTIVE_LOW_EN`.
- Defined: `led_out` is inverted at the output register, for boards with active-low LEDs. Its reset value is then 1; all other behaviour is identical.
- Undefined: `led_out` is active-high and its reset value is 0.

## Structure
- Package `led_stretch_pkg`:
  - state enum (IDLE/ON/OFF)
  - helper function for ns-to-cycle conversion
  - max-width helper
- One sub-module, `tick_timer`:
  - loadable down-counter with a `load`/`value` input and a `zero` flag
  - width set by parameter
  - instantiated once and shared by the ON and OFF phases

## Test plan
All scenarios use CLK_CYC=10, ON_TIME=100, OFF_TIME=50, PEND_MAX=3, which gives ON_CNT=10 and OFF_CNT=5.
- Single `evt_in` pulse at cycle 0 → `led_out` high in cycles 1–10, low from 11; `busy` high in 1–15, low at 16; `pend_cnt` stays 0.
- Pulses at cycles 0, 1, 2 → `pend_cnt` reaches 2 at cycle 3; blinks in cycles 1–10, 16–25 and 31–40; IDLE at cycle 46.
- Six pulses during the first ON phase → `pend_cnt` saturates at 3 and `overflow`=1; exactly 4 blinks total; `overflow` is still 1 after returning to IDLE.
- `pend_cnt`=1 with an event on the last OFF cycle (cycle 15) → `pend_cnt` stays 1 and the next blink starts at 16. Variant at `pend_cnt`=3: the count stays 3 and `overflow` stays 0.
- Assert `sysrst` at cycle 5 of an ON phase with `pend_cnt`=2 → next cycle `led_out`=0, `busy`=0, `pend_cnt`=0, `overflow`=0; a new event afterwards blinks normally.
- `LED_STRETCH_ACTIVE_LOW_EN` defined → `led_out`=1 at reset; the single-pulse scenario gives `led_out` low in cycles 1–10 and high otherwise.
